// File: rtl/lcd_pkg.sv
// Shared types, command bytes and transfer-sequencing helpers for the
// HD44780 character LCD writer.
package lcd_pkg;

    typedef enum logic [1:0] {S_POWERUP, S_INIT, S_IDLE, S_WRITE} state_e;
    typedef enum logic [1:0] {PH_SETUP, PH_EN, PH_WAIT} phase_e;

    localparam logic [7:0] LCD_FUNC_SET = 8'h38;
    localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
    localparam logic [7:0] LCD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_ENTRY    = 8'h06;
    localparam logic [7:0] LCD_ROW0     = 8'h80;
    localparam logic [7:0] LCD_ROW1     = 8'hC0;

    localparam int unsigned STR_W = 256;
    localparam int unsigned IDX_W = 6;

    localparam logic [IDX_W-1:0] INIT_LAST  = 6'd3;
    localparam logic [IDX_W-1:0] ROW1_IDX   = 6'd17;
    localparam logic [IDX_W-1:0] WRITE_LAST = 6'd33;

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
    } lcd_xfer_t;

    function automatic lcd_xfer_t init_item(input logic [1:0] n);
        case (n)
            2'd0:    return '{rs: 1'b0, data: LCD_FUNC_SET};
            2'd1:    return '{rs: 1'b0, data: LCD_DISP_ON};
            2'd2:    return '{rs: 1'b0, data: LCD_CLEAR};
            default: return '{rs: 1'b0, data: LCD_ENTRY};
        endcase
    endfunction

    // Refresh slot n: 0 = row-0 address, 17 = row-1 address, else a snapshot byte.
    function automatic lcd_xfer_t write_item(input logic [IDX_W-1:0] n,
                                             input logic [STR_W-1:0] snap);
        lcd_xfer_t   x;
        int unsigned k;
        x = '{rs: 1'b1, data: 8'h00};
        k = 0;
        if (n == '0) begin
            x = '{rs: 1'b0, data: LCD_ROW0};
        end else if (n == ROW1_IDX) begin
            x = '{rs: 1'b0, data: LCD_ROW1};
        end else begin
            if (n < ROW1_IDX) k = 32'(n) - 32'd1;
            else              k = 32'(n) - 32'd2;
            x.data = snap[k*8 +: 8];
        end
        return x;
    endfunction

    function automatic logic is_long(input lcd_xfer_t x);
        return (!x.rs) && (x.data == LCD_CLEAR);
    endfunction

endpackage

// File: rtl/lcd_bus_cycle.sv
// One LCD bus transfer: SETUP (1 cycle), EN high, then settle wait.
// o_done flags the final wait cycle so the next transfer can follow with no gap.
module lcd_bus_cycle
    import lcd_pkg::*;
#(
    parameter int unsigned EN_CYC  = 16,
    parameter int unsigned CMD_CYC = 2500,
    parameter int unsigned CLR_CYC = 82000,
    parameter int unsigned CNT_W   = 20
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_rs,
    input  logic [7:0] i_data,
    input  logic       i_long,
    output logic       o_done,
    output logic       o_LCD_EN,
    output logic       o_LCD_RS,
    output logic [7:0] o_LCD_DATA
);

    logic             active_q, active_d;
    phase_e           phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             long_q, long_d;
    logic             en_q, en_d;
    logic             rs_q, rs_d;
    logic [7:0]       data_q, data_d;
    logic             done_q, done_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            active_q <= 1'b0;
            phase_q  <= PH_SETUP;
            cnt_q    <= '0;
            long_q   <= 1'b0;
            en_q     <= 1'b0;
            rs_q     <= 1'b0;
            data_q   <= 8'h00;
            done_q   <= 1'b0;
        end else begin
            active_q <= active_d;
            phase_q  <= phase_d;
            cnt_q    <= cnt_d;
            long_q   <= long_d;
            en_q     <= en_d;
            rs_q     <= rs_d;
            data_q   <= data_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        active_d = active_q;
        phase_d  = phase_q;
        cnt_d    = cnt_q;
        long_d   = long_q;
        en_d     = en_q;
        rs_d     = rs_q;
        data_d   = data_q;
        if (i_start) begin
            active_d = 1'b1;
            phase_d  = PH_SETUP;
            cnt_d    = '0;
            long_d   = i_long;
            en_d     = 1'b0;
            rs_d     = i_rs;
            data_d   = i_data;
        end else if (active_q) begin
            case (phase_q)
                PH_SETUP: begin
                    phase_d = PH_EN;
                    cnt_d   = CNT_W'(EN_CYC - 1);
                    en_d    = 1'b1;
                end
                PH_EN: begin
                    if (cnt_q == '0) begin
                        phase_d = PH_WAIT;
                        en_d    = 1'b0;
                        cnt_d   = long_q ? CNT_W'(CLR_CYC - 1) : CNT_W'(CMD_CYC - 1);
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                PH_WAIT: begin
                    if (cnt_q == '0) active_d = 1'b0;
                    else             cnt_d    = cnt_q - CNT_W'(1);
                end
                default: phase_d = PH_SETUP;
            endcase
        end
        // RS/DATA are only reloaded on start, so they hold through all phases and idle.
        done_d = active_d && (phase_d == PH_WAIT) && (cnt_d == '0);
    end

    assign o_done     = done_q;
    assign o_LCD_EN   = en_q;
    assign o_LCD_RS   = rs_q;
    assign o_LCD_DATA = data_q;

endmodule

// File: rtl/lcd_writer.sv
// HD44780 16x2 writer: power-up wait, init commands, then full-screen refreshes
// of a snapshotted 32-character string on request.
module lcd_writer
    import lcd_pkg::*;
#(
    parameter int unsigned POWERUP_CYC = 750000,
    parameter int unsigned EN_CYC      = 16,
    parameter int unsigned CMD_CYC     = 2500,
    parameter int unsigned CLR_CYC     = 82000
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [STR_W-1:0] i_string,
    input  logic             i_update,
    output logic             o_busy,
    output logic [7:0]       o_LCD_DATA,
    output logic             o_LCD_EN,
    output logic             o_LCD_RS,
    output logic             o_LCD_RW,
    output logic             o_LCD_ON,
    output logic             o_LCD_BLON
);

    localparam int unsigned MAX_A   = (POWERUP_CYC > CLR_CYC) ? POWERUP_CYC : CLR_CYC;
    localparam int unsigned MAX_B   = (CMD_CYC > EN_CYC) ? CMD_CYC : EN_CYC;
    localparam int unsigned MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [STR_W-1:0] snap_q, snap_d;
    logic             pending_q, pending_d;
    logic             busy_q, busy_d;

    logic      start_c;
    logic      take_c;
    lcd_xfer_t xfer_c;
    logic      bus_done;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_POWERUP;
            cnt_q     <= '0;
            idx_q     <= '0;
            snap_q    <= '0;
            pending_q <= 1'b0;
            busy_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            snap_q    <= snap_d;
            pending_q <= pending_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        snap_d    = snap_q;
        pending_d = pending_q;
        start_c   = 1'b0;
        take_c    = 1'b0;
        xfer_c    = '{rs: 1'b0, data: 8'h00};

        case (state_q)
            S_POWERUP: begin
                if (cnt_q == CNT_W'(POWERUP_CYC - 1)) begin
                    state_d = S_INIT;
                    cnt_d   = '0;
                    idx_d   = '0;
                    start_c = 1'b1;
                    xfer_c  = init_item(2'd0);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_INIT: begin
                if (bus_done) begin
                    if (idx_q == INIT_LAST) begin
                        state_d = S_WRITE;
                        take_c  = 1'b1;
                    end else begin
                        idx_d   = idx_q + 6'd1;
                        start_c = 1'b1;
                        xfer_c  = init_item(idx_d[1:0]);
                    end
                end
            end
            S_WRITE: begin
                if (bus_done) begin
                    if (idx_q == WRITE_LAST) begin
                        // A request arriving on this very cycle counts as pending.
                        if (pending_q || i_update) take_c  = 1'b1;
                        else                       state_d = S_IDLE;
                    end else begin
                        idx_d   = idx_q + 6'd1;
                        start_c = 1'b1;
                        xfer_c  = write_item(idx_d, snap_q);
                    end
                end
            end
            S_IDLE: begin
                if (i_update) begin
                    state_d = S_WRITE;
                    take_c  = 1'b1;
                end
            end
            default: state_d = S_POWERUP;
        endcase

        // Snapshot starts a refresh and satisfies any outstanding request.
        if (take_c) begin
            snap_d    = i_string;
            idx_d     = '0;
            pending_d = 1'b0;
            start_c   = 1'b1;
            xfer_c    = write_item('0, i_string);
        end else if (i_update && (state_q != S_IDLE)) begin
            pending_d = 1'b1;
        end

        busy_d = (state_d != S_IDLE);
    end

    lcd_bus_cycle #(
        .EN_CYC  (EN_CYC),
        .CMD_CYC (CMD_CYC),
        .CLR_CYC (CLR_CYC),
        .CNT_W   (CNT_W)
    ) u_bus (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (start_c),
        .i_rs       (xfer_c.rs),
        .i_data     (xfer_c.data),
        .i_long     (is_long(xfer_c)),
        .o_done     (bus_done),
        .o_LCD_EN   (o_LCD_EN),
        .o_LCD_RS   (o_LCD_RS),
        .o_LCD_DATA (o_LCD_DATA)
    );

    assign o_busy     = busy_q;
    assign o_LCD_RW   = 1'b0;
    assign o_LCD_ON   = 1'b1;
    assign o_LCD_BLON = 1'b1;

endmodule

// File: tb/tb_lcd_writer.sv
// Bench for lcd_writer: per-cycle expected bus waveform built from the list of
// transfers each phase should produce, plus directed checks on captured bytes.
module tb_lcd_writer;

    localparam int unsigned P_PWR = 20;
    localparam int unsigned P_EN  = 2;
    localparam int unsigned P_CMD = 4;
    localparam int unsigned P_CLR = 10;

    logic         clk = 1'b0;
    logic         rst;
    logic         upd;
    logic [255:0] str;
    logic         busy, lcd_en, lcd_rs, lcd_rw, lcd_on, lcd_blon;
    logic [7:0]   lcd_data;

    always #5 clk = ~clk;

    lcd_writer #(
        .POWERUP_CYC (P_PWR),
        .EN_CYC      (P_EN),
        .CMD_CYC     (P_CMD),
        .CLR_CYC     (P_CLR)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_string   (str),
        .i_update   (upd),
        .o_busy     (busy),
        .o_LCD_DATA (lcd_data),
        .o_LCD_EN   (lcd_en),
        .o_LCD_RS   (lcd_rs),
        .o_LCD_RW   (lcd_rw),
        .o_LCD_ON   (lcd_on),
        .o_LCD_BLON (lcd_blon)
    );

    typedef struct packed {
        logic       en;
        logic       rs;
        logic [7:0] data;
    } cyc_t;

    cyc_t         exp_q[$];
    logic [8:0]   cap[$];
    int           kind;        // 0 idle, 1 power-up/init, 2 refresh
    bit           pend;
    bit           m_valid;
    logic         last_rs;
    logic [7:0]   last_data;
    logic         en_prev;
    logic         busy_prev;
    int           fall_cyc;
    int           n_checks;
    int           n_fail;
    int           cyc;
    logic [255:0] str_v;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic push_xfer(input logic rs, input logic [7:0] d);
        int unsigned w;
        w = (!rs && d == 8'h01) ? P_CLR : P_CMD;
        exp_q.push_back(cyc_t'({1'b0, rs, d}));
        for (int i = 0; i < int'(P_EN); i++) exp_q.push_back(cyc_t'({1'b1, rs, d}));
        for (int i = 0; i < int'(w); i++)    exp_q.push_back(cyc_t'({1'b0, rs, d}));
    endtask

    task automatic push_refresh(input logic [255:0] s);
        push_xfer(1'b0, 8'h80);
        for (int k = 0; k < 16; k++) push_xfer(1'b1, s[8*k +: 8]);
        push_xfer(1'b0, 8'hC0);
        for (int k = 16; k < 32; k++) push_xfer(1'b1, s[8*k +: 8]);
    endtask

    task automatic load_reset();
        exp_q.delete();
        pend = 1'b0;
        kind = 1;
        for (int i = 0; i < int'(P_PWR); i++) exp_q.push_back(cyc_t'(10'h000));
        push_xfer(1'b0, 8'h38);
        push_xfer(1'b0, 8'h0C);
        push_xfer(1'b0, 8'h01);
        push_xfer(1'b0, 8'h06);
    endtask

    function automatic logic [255:0] text(input string s);
        logic [255:0] v;
        v = {32{8'h20}};
        for (int i = 0; i < s.len() && i < 32; i++) v[8*i +: 8] = s[i];
        return v;
    endfunction

    function automatic logic [255:0] rand_str();
        logic [255:0] v;
        for (int k = 0; k < 32; k++) v[8*k +: 8] = 8'($urandom_range(32'h20, 32'h7E));
        return v;
    endfunction

    // One clock: compare this cycle's outputs, drive inputs, advance the model.
    task automatic step(input logic r, input logic u);
        cyc_t e;
        logic eb;
        bit   ended;
        bit   idle;
        ended = 1'b0;
        idle  = 1'b0;
        eb    = 1'b0;
        e     = cyc_t'(10'h000);
        @(posedge clk);
        #1;
        cyc++;
        if (m_valid) begin
            if (exp_q.size() > 0) begin
                e         = exp_q.pop_front();
                eb        = 1'b1;
                last_rs   = e.rs;
                last_data = e.data;
                ended     = (exp_q.size() == 0);
            end else begin
                e    = cyc_t'({1'b0, last_rs, last_data});
                idle = 1'b1;
            end
            check_eq("bus{busy,en,rs,data}", 64'({busy, lcd_en, lcd_rs, lcd_data}), 64'({eb, e}));
        end
        if (lcd_en && !en_prev) cap.push_back({lcd_rs, lcd_data});
        en_prev = lcd_en;
        if (busy_prev && !busy && fall_cyc < 0) fall_cyc = cyc;
        busy_prev = busy;

        rst = r;
        upd = u;
        str = str_v;
        if (r) begin
            load_reset();
            m_valid = 1'b1;
        end else if (m_valid) begin
            if (ended && kind == 1) begin
                push_refresh(str_v);
                kind = 2;
                pend = 1'b0;
            end else if (ended && kind == 2) begin
                if (pend || u) begin
                    push_refresh(str_v);
                    pend = 1'b0;
                end else begin
                    kind = 0;
                end
            end else if (idle) begin
                if (u) begin
                    push_refresh(str_v);
                    kind = 2;
                    pend = 1'b0;
                end
            end else if (u) begin
                pend = 1'b1;
            end
        end
    endtask

    task automatic run_idle(input int max_cyc);
        int n;
        n = 0;
        while (!(kind == 0 && exp_q.size() == 0) && n < max_cyc) begin
            step(1'b0, 1'b0);
            n++;
        end
        step(1'b0, 1'b0);
        check_eq("idle_reached", 64'(busy), 64'(0));
    endtask

    initial begin
        int           cyc0;
        int           n;
        logic [255:0] a;
        logic [255:0] h;

        rst = 1'b1; upd = 1'b0; m_valid = 1'b0; kind = 0; pend = 1'b0;
        last_rs = 1'b0; last_data = 8'h00; en_prev = 1'b0; busy_prev = 1'b1;
        fall_cyc = -1; n_checks = 0; n_fail = 0; cyc = 0;
        str_v = text("Original Picture");
        str = str_v;

        // Power-up, init and the automatic first refresh.
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        cyc0 = cyc + 1;
        cap.delete();
        fall_cyc = -1;
        busy_prev = 1'b1;
        run_idle(2000);
        check_eq("busy_fall_cycle", 64'(fall_cyc - cyc0), 64'(292));
        check_eq("xfer_count", 64'(cap.size()), 64'(38));
        if (cap.size() >= 38) begin
            check_eq("init0", 64'(cap[0]), 64'(9'h038));
            check_eq("init1", 64'(cap[1]), 64'(9'h00C));
            check_eq("init2", 64'(cap[2]), 64'(9'h001));
            check_eq("init3", 64'(cap[3]), 64'(9'h006));
            check_eq("row0",  64'(cap[4]), 64'(9'h080));
            check_eq("ch_O",  64'(cap[5]), 64'(9'h14F));
            check_eq("ch_r",  64'(cap[6]), 64'(9'h172));
            check_eq("ch_i",  64'(cap[7]), 64'(9'h169));
            check_eq("row1",  64'(cap[21]), 64'(9'h0C0));
            check_eq("space", 64'(cap[37]), 64'(9'h120));
        end

        // String changes mid-refresh without a request: snapshot wins.
        a = rand_str();
        str_v = a;
        cap.delete();
        step(1'b0, 1'b1);
        repeat (35) step(1'b0, 1'b0);
        str_v = rand_str();
        run_idle(1000);
        check_eq("snap_count", 64'(cap.size()), 64'(34));
        if (cap.size() >= 34) begin
            for (int k = 0; k < 16; k++) begin
                check_eq("snap_row0", 64'(cap[1+k]), 64'({1'b1, a[8*k +: 8]}));
                check_eq("snap_row1", 64'(cap[18+k]), 64'({1'b1, a[8*(k+16) +: 8]}));
            end
        end

        // Two requests during a refresh collapse into one follow-up refresh.
        str_v = rand_str();
        cap.delete();
        step(1'b0, 1'b1);
        repeat (30) step(1'b0, 1'b0);
        str_v = rand_str();
        step(1'b0, 1'b1);
        repeat (40) step(1'b0, 1'b0);
        str_v = rand_str();
        step(1'b0, 1'b1);
        repeat (20) step(1'b0, 1'b0);
        h = rand_str();
        str_v = h;
        run_idle(1000);
        check_eq("collapse_count", 64'(cap.size()), 64'(68));
        if (cap.size() >= 68) begin
            check_eq("second_row0", 64'(cap[34]), 64'(9'h080));
            check_eq("second_first", 64'(cap[35]), 64'({1'b1, h[7:0]}));
            check_eq("second_last", 64'(cap[67]), 64'({1'b1, h[255:248]}));
        end

        // Request on the final wait cycle of a refresh.
        str_v = rand_str();
        cap.delete();
        step(1'b0, 1'b1);
        n = 0;
        while (!(kind == 2 && exp_q.size() == 1) && n < 500) begin
            step(1'b0, 1'b0);
            n++;
        end
        h = rand_str();
        str_v = h;
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        check_eq("busy_held", 64'(busy), 64'(1));
        run_idle(1000);
        check_eq("edge_req_count", 64'(cap.size()), 64'(68));
        if (cap.size() >= 68) check_eq("edge_req_first", 64'(cap[35]), 64'({1'b1, h[7:0]}));

        // Reset while EN is high on a data transfer.
        str_v = rand_str();
        step(1'b0, 1'b1);
        n = 0;
        while (!(exp_q.size() > 0 && exp_q[0].en && exp_q[0].rs && exp_q.size() < 200) && n < 500) begin
            step(1'b0, 1'b0);
            n++;
        end
        step(1'b1, 1'b0);
        check_eq("en_before_rst", 64'(lcd_en), 64'(1));
        cap.delete();
        step(1'b0, 1'b0);
        check_eq("rst_en", 64'(lcd_en), 64'(0));
        check_eq("rst_data", 64'(lcd_data), 64'(0));
        check_eq("rst_busy", 64'(busy), 64'(1));
        run_idle(2000);
        if (cap.size() >= 4) begin
            check_eq("reinit0", 64'(cap[0]), 64'(9'h038));
            check_eq("reinit3", 64'(cap[3]), 64'(9'h006));
        end else begin
            check_eq("reinit_count", 64'(cap.size()), 64'(38));
        end

        // Random requests, string changes and occasional resets.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 49) == 0) str_v = rand_str();
            step(1'b0 || ($urandom_range(0, 1499) == 0), $urandom_range(0, 39) == 0);
        end
        run_idle(3000);

        check_eq("tied_rw_on_blon", 64'({lcd_rw, lcd_on, lcd_blon}), 64'(3'b011));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd_writer.md
Name: lcd_writer

Overview:
- Downstream consumer of the LCD character generator's 256-bit string.
- Drives the HD44780-compatible 16x2 character LCD on the board: power-up wait, controller initialisation, then full-screen refreshes of both rows.
- A refresh is requested by a one-cycle pulse. The string is snapshotted at refresh start, so the upstream message can change freely mid-refresh.

Parameters:
- POWERUP_CYC, 750000: cycles to wait after reset before the first command (15 ms at 50 MHz).
- EN_CYC, 16: cycles LCD_EN is held high per transfer.
- CMD_CYC, 2500: post-transfer wait for normal commands and data (50 us).
- CLR_CYC, 82000: post-transfer wait after the clear-display command (1.64 ms).

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous, active-high reset
- i_string  in  256  characters; byte k = i_string[8k+:8]; k=0..15 row 1 left-to-right, k=16..31 row 2
- i_update  in  1  one-cycle refresh request
- o_busy  out  1  high during power-up, init, or refresh
- o_LCD_DATA  out  8  LCD data bus
- o_LCD_EN  out  1  LCD enable strobe
- o_LCD_RS  out  1  0 = command, 1 = data
- o_LCD_RW  out  1  tied 0 (write only)
- o_LCD_ON  out  1  tied 1
- o_LCD_BLON  out  1  tied 1

Behaviour:
- Reset (synchronous, any state, including mid-transfer):
  - FSM goes to S_POWERUP; all counters clear; pending flag clears.
  - o_LCD_DATA=0, o_LCD_EN=0, o_LCD_RS=0, o_busy=1.
- Transfer phases, each transfer:
  - SETUP: 1 cycle, RS/DATA driven, EN=0.
  - EN_HIGH: EN_CYC cycles, EN=1.
  - WAIT: CMD_CYC cycles, or CLR_CYC when data is 8'h01; EN=0.
  - RS/DATA are held stable through all three phases.
  - Total per transfer = 1+EN_CYC+wait cycles.
- FSM states:
  - S_POWERUP: count POWERUP_CYC cycles, then go to S_INIT.
  - S_INIT: commands in order 8'h38 (8-bit, 2 lines), 8'h0C (display on, cursor off), 8'h01 (clear), 8'h06 (increment, no shift). Then go to S_WRITE; the first refresh is automatic and uses i_string sampled on S_INIT exit.
  - S_WRITE: 34 transfers, index 0..33:
    - 0: cmd 8'h80
    - 1..16: data bytes k=0..15
    - 17: cmd 8'hC0
    - 18..33: data bytes k=16..31
    - After index 33 WAIT completes, go to S_IDLE, or back to S_WRITE (new snapshot) if pending is set.
  - S_IDLE: o_busy=0; EN=0; RS/DATA hold their last values. i_update=1 latches i_string and enters S_WRITE next cycle.
- i_update while busy:
  - Sets the pending flag. Multiple requests collapse into one.
  - Pending is cleared when the next refresh snapshot is taken.
  - i_update on the exact cycle S_WRITE finishes is treated as pending and is not lost.
- Counters:
  - Wide enough for the largest parameter: $clog2(POWERUP_CYC+1).
  - The transfer index is 6 bits and never wraps past 33.
- The string snapshot register (256 bits) is the only wide state.

Decomposition:
- Shared package lcd_pkg:
  - FSM state enum {S_POWERUP, S_INIT, S_IDLE, S_WRITE}.
  - Phase enum {PH_SETUP, PH_EN, PH_WAIT}.
  - Command constants LCD_FUNC_SET=8'h38, LCD_DISP_ON=8'h0C, LCD_CLEAR=8'h01, LCD_ENTRY=8'h06, LCD_ROW0=8'h80, LCD_ROW1=8'hC0.
- Sub-module lcd_bus_cycle performs one transfer:
  - Inputs: i_start, i_rs, i_data, i_long.
  - Outputs: the bus signals and o_done, a one-cycle pulse at the end of WAIT.
  - lcd_writer sequences transfers through it.

Test Plan (POWERUP_CYC=20, EN_CYC=2, CMD_CYC=4, CLR_CYC=10):
- Reset then idle inputs -> no EN pulse for 20 cycles. Then init bytes 38,0C,01,06 with RS=0; EN high exactly 2 cycles each; clear transfer spans 13 cycles, others 7. o_busy=1 throughout.
- i_string = "Original Picture" row 1, spaces row 2 -> after init: 80, then ASCII 4F,72,69,... (RS=1), C0, then 16×8'h20. o_busy falls 238 cycles after refresh start.
- Change i_string at refresh index 5 without i_update -> displayed bytes still match the snapshot.
- Two i_update pulses during refresh -> exactly one extra refresh follows immediately, showing the string present at its start; then idle.
- i_update on the cycle the final WAIT ends -> second refresh starts, o_busy stays 1.
- Assert i_rst mid-data transfer with EN high -> next cycle EN=0, DATA=0, o_busy=1; full power-up and init sequence repeats.
